// File: rtl/tone_voice_gen.sv
// Keyboard tone voice: decodes an ASCII key into one of 12 notes, scales it by an octave
// shift and drives a square wave whose pitch changes and note endings land on waveform edges.
module tone_voice_gen #(
  parameter int CLK_HZ         = 50000000,
  parameter int CNT_W          = 26,
  parameter int SUSTAIN_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       ascii,
  input  logic             key_down,
  input  logic [1:0]       octave,
  input  logic             enable,
  output logic             speaker,
  output logic             note_active,
  output logic [3:0]       note_idx,
  output logic [CNT_W-1:0] half_period
);

  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN, STOP} state_t;

  localparam logic [32:0] HP_MAX   = {{(33-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [31:0] SUS_LOAD = (SUSTAIN_CYCLES > 0) ? 32'(SUSTAIN_CYCLES - 1) : 32'd0;

  state_t             state_q, state_d;
  logic               speaker_q, speaker_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   pend_hp_q, pend_hp_d;
  logic [3:0]         pend_idx_q, pend_idx_d;
  logic [31:0]        sus_q, sus_d;

  logic               key_ok;
  logic               valid;
  logic [3:0]         req_idx;
  logic [31:0]        base;
  logic [32:0]        scaled;
  logic [CNT_W-1:0]   req_hp;
  logic [CNT_W-1:0]   eff_hp;
  logic [3:0]         eff_idx;

  // Constant argument at every call site, so the division folds away at elaboration.
  function automatic logic [31:0] hzToHp(input int hz);
    return 32'(CLK_HZ / (2 * hz));
  endfunction

  always_comb begin
    key_ok  = 1'b1;
    req_idx = 4'd0;
    base    = 32'd0;
    case (ascii)
      7'd65:   begin req_idx = 4'd0;  base = hzToHp(1047); end
      7'd87:   begin req_idx = 4'd1;  base = hzToHp(1109); end
      7'd83:   begin req_idx = 4'd2;  base = hzToHp(1175); end
      7'd69:   begin req_idx = 4'd3;  base = hzToHp(1245); end
      7'd68:   begin req_idx = 4'd4;  base = hzToHp(1319); end
      7'd70:   begin req_idx = 4'd5;  base = hzToHp(1397); end
      7'd84:   begin req_idx = 4'd6;  base = hzToHp(1480); end
      7'd71:   begin req_idx = 4'd7;  base = hzToHp(1568); end
      7'd89:   begin req_idx = 4'd8;  base = hzToHp(1661); end
      7'd72:   begin req_idx = 4'd9;  base = hzToHp(1760); end
      7'd85:   begin req_idx = 4'd10; base = hzToHp(1865); end
      7'd74:   begin req_idx = 4'd11; base = hzToHp(1976); end
      default: key_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (octave)
      2'd0:    scaled = {base, 1'b0};
      2'd1:    scaled = {1'b0, base};
      2'd2:    scaled = {2'b00, base[31:1]};
      default: scaled = {3'b000, base[31:2]};
    endcase
    if (scaled > HP_MAX)       req_hp = '1;
    else if (scaled == 33'd0)  req_hp = CNT_W'(1);
    else                       req_hp = scaled[CNT_W-1:0];
  end

  // The newest valid request wins; otherwise the tone keeps its last pending note.
  assign valid   = enable && key_down && key_ok;
  assign eff_hp  = valid ? req_hp  : pend_hp_q;
  assign eff_idx = valid ? req_idx : pend_idx_q;

  always_comb begin
    state_d    = state_q;
    speaker_d  = speaker_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    idx_d      = idx_q;
    pend_hp_d  = eff_hp;
    pend_idx_d = eff_idx;
    sus_d      = sus_q;
    if (!enable) begin
      state_d   = IDLE;
      speaker_d = 1'b0;
      cnt_d     = '0;
    end else if (state_q == IDLE) begin
      speaker_d = 1'b0;
      if (valid) begin
        state_d   = PLAY;
        speaker_d = 1'b1;
        cnt_d     = req_hp - CNT_W'(1);
        half_d    = req_hp;
        idx_d     = req_idx;
      end
    end else begin
      if (cnt_q == '0) begin
        speaker_d = ~speaker_q;
        cnt_d     = eff_hp - CNT_W'(1);
        half_d    = eff_hp;
        idx_d     = eff_idx;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      case (state_q)
        PLAY: begin
          if (!valid) begin
            if (SUSTAIN_CYCLES == 0) begin
              state_d = STOP;
            end else begin
              state_d = SUSTAIN;
              sus_d   = SUS_LOAD;
            end
          end
        end
        SUSTAIN: begin
          if (valid)              state_d = PLAY;
          else if (sus_q == 32'd0) state_d = STOP;
          else                    sus_d = sus_q - 32'd1;
        end
        STOP: begin
          // Leave only once the output is low, so the last half-cycle is never cut short.
          if (valid) begin
            state_d = PLAY;
          end else if (!speaker_q || cnt_q == '0) begin
            state_d   = IDLE;
            speaker_d = 1'b0;
            cnt_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      speaker_q  <= 1'b0;
      cnt_q      <= '0;
      half_q     <= '0;
      idx_q      <= 4'd0;
      pend_hp_q  <= '0;
      pend_idx_q <= 4'd0;
      sus_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      speaker_q  <= speaker_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      idx_q      <= idx_d;
      pend_hp_q  <= pend_hp_d;
      pend_idx_q <= pend_idx_d;
      sus_q      <= sus_d;
    end
  end

  assign speaker     = speaker_q;
  assign note_active = (state_q != IDLE);
  assign note_idx    = idx_q;
  assign half_period = half_q;

endmodule

// File: tb/tb_tone_voice_gen.sv
// Bench for tone_voice_gen: a table of single-press vectors plus hand-written sequences
// covering pitch changes at edges, sustain, stop, enable, async reset and saturation.
module tb_tone_voice_gen;

  logic        clk;
  logic        reset;
  logic [6:0]  ascii;
  logic        keyDown;
  logic [1:0]  octave;
  logic        enable;
  logic        speaker, noteActive;
  logic [3:0]  noteIdx;
  logic [25:0] halfPeriod;
  logic        speaker2, noteActive2;
  logic [3:0]  noteIdx2;
  logic [1:0]  halfPeriod2;

  int checks   = 0;
  int failures = 0;

  tone_voice_gen #(.CLK_HZ(1000000), .CNT_W(26), .SUSTAIN_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .ascii(ascii), .key_down(keyDown), .octave(octave),
    .enable(enable), .speaker(speaker), .note_active(noteActive), .note_idx(noteIdx),
    .half_period(halfPeriod)
  );

  // Tiny clock and 2-bit counter so octave saturation, the zero-to-one clamp and
  // the no-sustain path are all reachable.
  tone_voice_gen #(.CLK_HZ(5000), .CNT_W(2), .SUSTAIN_CYCLES(0)) dutSmall (
    .clk(clk), .reset(reset), .ascii(ascii), .key_down(keyDown), .octave(octave),
    .enable(enable), .speaker(speaker2), .note_active(noteActive2), .note_idx(noteIdx2),
    .half_period(halfPeriod2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ascii;
    logic        keyDown;
    logic [1:0]  octave;
    logic        expActive;
    logic [3:0]  expIdx;
    logic [25:0] expHp;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mkVec(logic [6:0] a, logic k, logic [1:0] o, logic act,
                                 logic [3:0] idx, logic [25:0] hp);
    vec_t v;
    v.ascii = a; v.keyDown = k; v.octave = o; v.expActive = act; v.expIdx = idx; v.expHp = hp;
    return v;
  endfunction

  task automatic applyStimulus(input logic [6:0] a, input logic k, input logic [1:0] o,
                               input logic en);
    ascii   = a;
    keyDown = k;
    octave  = o;
    enable  = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Clocks until speaker changes level; -1 if it never does within the budget.
  task automatic waitToggle(output int n);
    logic start;
    bit   done;
    start = speaker;
    done  = 1'b0;
    n     = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (speaker !== start) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  task automatic waitIdle(output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (noteActive === 1'b0) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  initial begin
    int n;
    vecs[0]  = mkVec(7'd66, 1'b1, 2'd1, 1'b0, 4'd0,  26'd0);
    vecs[1]  = mkVec(7'd65, 1'b1, 2'd1, 1'b1, 4'd0,  26'd477);
    vecs[2]  = mkVec(7'd87, 1'b1, 2'd1, 1'b1, 4'd1,  26'd450);
    vecs[3]  = mkVec(7'd83, 1'b1, 2'd0, 1'b1, 4'd2,  26'd850);
    vecs[4]  = mkVec(7'd69, 1'b1, 2'd2, 1'b1, 4'd3,  26'd200);
    vecs[5]  = mkVec(7'd68, 1'b1, 2'd3, 1'b1, 4'd4,  26'd94);
    vecs[6]  = mkVec(7'd70, 1'b1, 2'd1, 1'b1, 4'd5,  26'd357);
    vecs[7]  = mkVec(7'd84, 1'b1, 2'd1, 1'b1, 4'd6,  26'd337);
    vecs[8]  = mkVec(7'd71, 1'b1, 2'd0, 1'b1, 4'd7,  26'd636);
    vecs[9]  = mkVec(7'd89, 1'b1, 2'd2, 1'b1, 4'd8,  26'd150);
    vecs[10] = mkVec(7'd72, 1'b1, 2'd1, 1'b1, 4'd9,  26'd284);
    vecs[11] = mkVec(7'd85, 1'b1, 2'd3, 1'b1, 4'd10, 26'd67);
    vecs[12] = mkVec(7'd74, 1'b1, 2'd3, 1'b1, 4'd11, 26'd63);
    vecs[13] = mkVec(7'd97, 1'b1, 2'd1, 1'b0, 4'd11, 26'd63);
    vecs[14] = mkVec(7'd65, 1'b0, 2'd1, 1'b0, 4'd11, 26'd63);

    reset = 1'b1;
    applyStimulus(7'd0, 1'b0, 2'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstSpeaker", 32'(speaker), 32'd0);
    checkOutput("rstActive", 32'(noteActive), 32'd0);
    checkOutput("rstIdx", 32'(noteIdx), 32'd0);
    checkOutput("rstHp", 32'(halfPeriod), 32'd0);
    reset = 1'b0;

    // Each vector: one press from IDLE, then enable low to return to IDLE.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].ascii, vecs[i].keyDown, vecs[i].octave, 1'b1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0dSpeaker", i), 32'(speaker), 32'(vecs[i].expActive));
      checkOutput($sformatf("vec%0dActive", i), 32'(noteActive), 32'(vecs[i].expActive));
      checkOutput($sformatf("vec%0dIdx", i), 32'(noteIdx), 32'(vecs[i].expIdx));
      checkOutput($sformatf("vec%0dHp", i), 32'(halfPeriod), 32'(vecs[i].expHp));
      applyStimulus(vecs[i].ascii, vecs[i].keyDown, vecs[i].octave, 1'b0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0dOffSpeaker", i), 32'(speaker), 32'd0);
      checkOutput($sformatf("vec%0dOffActive", i), 32'(noteActive), 32'd0);
    end

    $display("[TB] steady A tone");
    applyStimulus(7'd65, 1'b1, 2'd1, 1'b1);
    @(posedge clk); #1;
    checkOutput("aRise", 32'(speaker), 32'd1);
    waitToggle(n);
    checkOutput("aHigh477", 32'(n), 32'd477);
    waitToggle(n);
    checkOutput("aLow477", 32'(n), 32'd477);

    $display("[TB] switch to H mid half-cycle");
    repeat (100) @(posedge clk);
    #1;
    applyStimulus(7'd72, 1'b1, 2'd1, 1'b1);
    waitToggle(n);
    checkOutput("hFinishA", 32'(n), 32'd377);
    checkOutput("hIdx", 32'(noteIdx), 32'd9);
    checkOutput("hHp", 32'(halfPeriod), 32'd284);
    waitToggle(n);
    checkOutput("hHalf", 32'(n), 32'd284);

    $display("[TB] octave changes");
    applyStimulus(7'd65, 1'b1, 2'd2, 1'b1);
    waitToggle(n);
    checkOutput("oct2Wait", 32'(n), 32'd284);
    checkOutput("oct2Hp", 32'(halfPeriod), 32'd238);
    applyStimulus(7'd65, 1'b1, 2'd0, 1'b1);
    waitToggle(n);
    checkOutput("oct0Wait", 32'(n), 32'd238);
    checkOutput("oct0Hp", 32'(halfPeriod), 32'd954);
    applyStimulus(7'd65, 1'b1, 2'd3, 1'b1);
    waitToggle(n);
    checkOutput("oct3Wait", 32'(n), 32'd954);
    checkOutput("oct3Hp", 32'(halfPeriod), 32'd119);
    waitToggle(n);
    checkOutput("oct3Half", 32'(n), 32'd119);

    $display("[TB] release, sustain and stop");
    applyStimulus(7'd65, 1'b0, 2'd3, 1'b1);
    waitIdle(n);
    checkOutput("stopEdge", 32'(n), 32'd1071);
    checkOutput("stopSpeaker", 32'(speaker), 32'd0);

    $display("[TB] re-press during sustain");
    applyStimulus(7'd65, 1'b1, 2'd1, 1'b1);
    @(posedge clk); #1;
    checkOutput("repRise", 32'(speaker), 32'd1);
    applyStimulus(7'd65, 1'b0, 2'd1, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("susActive", 32'(noteActive), 32'd1);
    applyStimulus(7'd65, 1'b1, 2'd1, 1'b1);
    waitToggle(n);
    checkOutput("repNoRestart", 32'(n), 32'd427);
    waitToggle(n);
    checkOutput("repFull", 32'(n), 32'd477);

    $display("[TB] enable drop and invalid key");
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(7'd65, 1'b1, 2'd1, 1'b0);
    @(posedge clk); #1;
    checkOutput("enSpeaker", 32'(speaker), 32'd0);
    checkOutput("enActive", 32'(noteActive), 32'd0);
    checkOutput("enHoldHp", 32'(halfPeriod), 32'd477);
    applyStimulus(7'd66, 1'b1, 2'd1, 1'b1);
    @(posedge clk); #1;
    checkOutput("badKeySpeaker", 32'(speaker), 32'd0);
    checkOutput("badKeyActive", 32'(noteActive), 32'd0);

    $display("[TB] asynchronous reset mid half-cycle");
    applyStimulus(7'd65, 1'b1, 2'd1, 1'b1);
    @(posedge clk); #1;
    checkOutput("preRstRise", 32'(speaker), 32'd1);
    repeat (100) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncSpeaker", 32'(speaker), 32'd0);
    checkOutput("asyncActive", 32'(noteActive), 32'd0);
    checkOutput("asyncIdx", 32'(noteIdx), 32'd0);
    checkOutput("asyncHp", 32'(halfPeriod), 32'd0);
    @(posedge clk); #1;
    checkOutput("rstHeldSpeaker", 32'(speaker), 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("postRstRise", 32'(speaker), 32'd1);
    checkOutput("postRstHp", 32'(halfPeriod), 32'd477);
    waitToggle(n);
    checkOutput("postRstHalf", 32'(n), 32'd477);

    $display("[TB] saturation, clamp and no-sustain stop");
    reset = 1'b1;
    applyStimulus(7'd65, 1'b1, 2'd0, 1'b1);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("satSpeaker", 32'(speaker2), 32'd1);
    checkOutput("satHp", 32'(halfPeriod2), 32'd3);
    applyStimulus(7'd65, 1'b1, 2'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("clampHp", 32'(halfPeriod2), 32'd1);
    applyStimulus(7'd65, 1'b0, 2'd3, 1'b1);
    @(posedge clk); #1;
    checkOutput("noSusStop", 32'(noteActive2), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("noSusIdle", 32'(noteActive2), 32'd0);
    checkOutput("noSusLow", 32'(speaker2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
